// File: rtl/seq_mult_core.sv
// Multi-cycle shift-add multiplier for signed or unsigned WIDTH x WIDTH operands.
// Handshakes: valid/ready on the operand input and on the result output.
module seq_mult_core #(
  parameter int WIDTH = 16,
  localparam int ZW = 2*WIDTH + 1
) (
  input  logic             sig_clk,
  input  logic             sig_rst,
  input  logic [WIDTH-1:0] sig_a,
  input  logic [WIDTH-1:0] sig_b,
  input  logic             sig_signed,
  input  logic             sig_ab_valid,
  output logic             sig_ab_ready,
  output logic [ZW-1:0]    sig_z,
  output logic             sig_z_valid,
  input  logic             sig_z_ready,
  output logic [WIDTH-1:0] sig_a_real,
  output logic [WIDTH-1:0] sig_b_real,
  output logic             sig_busy
);

  localparam int AW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               ab_ready_q, ab_ready_d;
  logic               z_valid_q, z_valid_d;
  logic               busy_q, busy_d;
  logic [ZW-1:0]      z_q, z_d;
  logic [WIDTH-1:0]   a_real_q, a_real_d;
  logic [WIDTH-1:0]   b_real_q, b_real_d;
  logic               signed_q, signed_d;
  logic               neg_q, neg_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               xfer_s;
  logic               take_s;
  logic [AW-1:0]      acc_sum_s;
  logic [AW-1:0]      prod_s;

  // Most-negative input maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      magnitude = ~v + WIDTH'(1'b1);
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [ZW-1:0] extend(input logic [AW-1:0] v, input logic sgn);
    if (sgn) begin
      extend = {v[AW-1], v};
    end else begin
      extend = {1'b0, v};
    end
  endfunction

  assign xfer_s    = sig_ab_valid && ab_ready_q;
  assign take_s    = z_valid_q && sig_z_ready;
  assign acc_sum_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign prod_s    = neg_q ? (~acc_sum_s + AW'(1'b1)) : acc_sum_s;

  // Next-state and datapath: the multiplicand shifts left so each add is (mcand << count).
  always_comb begin
    state_d    = state_q;
    z_valid_d  = z_valid_q;
    z_d        = z_q;
    a_real_d   = a_real_q;
    b_real_d   = b_real_q;
    signed_d   = signed_q;
    neg_d      = neg_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ab_ready_d = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          state_d  = CALC;
          a_real_d = sig_a;
          b_real_d = sig_b;
          signed_d = sig_signed;
          neg_d    = sig_signed && (sig_a[WIDTH-1] ^ sig_b[WIDTH-1]);
          mcand_d  = {{WIDTH{1'b0}}, magnitude(sig_a, sig_signed)};
          mplier_d = magnitude(sig_b, sig_signed);
          acc_d    = {AW{1'b0}};
          cnt_d    = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d    = acc_sum_s;
        mcand_d  = {mcand_q[AW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1'b1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d   = DONE;
          z_d       = extend(prod_s, signed_q);
          z_valid_d = 1'b1;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (take_s) begin
          state_d   = IDLE;
          z_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        z_valid_d = 1'b0;
      end
    endcase
    // Ready and busy are registered copies of where the FSM is heading.
    if (state_d == IDLE) begin
      ab_ready_d = 1'b1;
      busy_d     = 1'b0;
    end else begin
      ab_ready_d = 1'b0;
      busy_d     = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge sig_clk) begin
    if (!sig_rst) begin
      state_q    <= IDLE;
      ab_ready_q <= 1'b0;
      z_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      z_q        <= {ZW{1'b0}};
      a_real_q   <= {WIDTH{1'b0}};
      b_real_q   <= {WIDTH{1'b0}};
      signed_q   <= 1'b0;
      neg_q      <= 1'b0;
      mcand_q    <= {AW{1'b0}};
      mplier_q   <= {WIDTH{1'b0}};
      acc_q      <= {AW{1'b0}};
      cnt_q      <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      ab_ready_q <= ab_ready_d;
      z_valid_q  <= z_valid_d;
      busy_q     <= busy_d;
      z_q        <= z_d;
      a_real_q   <= a_real_d;
      b_real_q   <= b_real_d;
      signed_q   <= signed_d;
      neg_q      <= neg_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sig_ab_ready = ab_ready_q;
  assign sig_z        = z_q;
  assign sig_z_valid  = z_valid_q;
  assign sig_a_real   = a_real_q;
  assign sig_b_real   = b_real_q;
  assign sig_busy     = busy_q;

endmodule

// File: tb/tb_seq_mult_core.sv
// Bench for seq_mult_core: cycle-level reference model for WIDTH=16 plus
// directed literal checks for WIDTH=16 and WIDTH=8 instances.
module tb_seq_mult_core;
  localparam int W   = 16;
  localparam int ZW  = 2*W + 1;
  localparam int W8  = 8;
  localparam int ZW8 = 2*W8 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  a, b;
  logic          sgn, ab_valid, z_ready;
  logic          ab_ready16, z_valid16, busy16;
  logic [ZW-1:0] z16;
  logic [W-1:0]  a_real16, b_real16;

  logic [W8-1:0]  a8, b8;
  logic           sgn8, ab_valid8, z_ready8;
  logic           ab_ready8, z_valid8, busy8;
  logic [ZW8-1:0] z8;
  logic [W8-1:0]  a_real8, b_real8;

  seq_mult_core #(.WIDTH(W)) u16 (
    .sig_clk(clk), .sig_rst(rst_n), .sig_a(a), .sig_b(b), .sig_signed(sgn),
    .sig_ab_valid(ab_valid), .sig_ab_ready(ab_ready16), .sig_z(z16),
    .sig_z_valid(z_valid16), .sig_z_ready(z_ready), .sig_a_real(a_real16),
    .sig_b_real(b_real16), .sig_busy(busy16));

  seq_mult_core #(.WIDTH(W8)) u8 (
    .sig_clk(clk), .sig_rst(rst_n), .sig_a(a8), .sig_b(b8), .sig_signed(sgn8),
    .sig_ab_valid(ab_valid8), .sig_ab_ready(ab_ready8), .sig_z(z8),
    .sig_z_valid(z_valid8), .sig_z_ready(z_ready8), .sig_a_real(a_real8),
    .sig_b_real(b_real8), .sig_busy(busy8));

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [ZW-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint xa, ya, p;
    xa = {{48{s & x[W-1]}}, x};
    ya = {{48{s & y[W-1]}}, y};
    p  = xa * ya;
    return p[ZW-1:0];
  endfunction

  // Transaction-level model: accept, fixed W-cycle wait, hold until taken.
  logic          m_ready, m_busy, m_zv;
  logic [ZW-1:0] m_z, m_res;
  logic [W-1:0]  m_ar, m_br;
  bit            m_pending;
  int            m_left;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready = 1'b0; m_busy = 1'b0; m_zv = 1'b0; m_z = '0; m_res = '0;
      m_ar = '0; m_br = '0; m_pending = 1'b0; m_left = 0;
    end else if (m_zv) begin
      if (z_ready) begin
        m_zv = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
      end
    end else if (m_pending) begin
      m_left--;
      if (m_left == 0) begin
        m_pending = 1'b0; m_zv = 1'b1; m_z = m_res;
      end
    end else if (m_ready && ab_valid) begin
      m_ar = a; m_br = b; m_res = ref_prod(a, b, sgn);
      m_pending = 1'b1; m_left = W; m_busy = 1'b1; m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("ab_ready", 64'(ab_ready16), 64'(m_ready));
      chk("busy",     64'(busy16),     64'(m_busy));
      chk("z_valid",  64'(z_valid16),  64'(m_zv));
      chk("z",        64'(z16),        64'(m_z));
      chk("a_real",   64'(a_real16),   64'(m_ar));
      chk("b_real",   64'(b_real16),   64'(m_br));
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic op16(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                      input logic [ZW-1:0] expz, input int hold, input bit wiggle, input string name);
    int n;
    n = 0;
    while (!ab_ready16 && n < 50) begin @(negedge clk); n++; end
    chk({name, "_ready"}, 64'(ab_ready16), 64'd1);
    a = x; b = y; sgn = s; ab_valid = 1'b1; z_ready = (hold == 0);
    @(negedge clk);
    chk({name, "_busy"}, 64'(busy16), 64'd1);
    if (!wiggle) ab_valid = 1'b0;
    n = 0;
    while (!z_valid16 && n < 40) begin
      if (wiggle) begin a = W'($urandom); b = W'($urandom); sgn = 1'($urandom); end
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(W));
    chk({name, "_z"}, 64'(z16), 64'(expz));
    chk({name, "_a_real"}, 64'(a_real16), 64'(x));
    chk({name, "_b_real"}, 64'(b_real16), 64'(y));
    repeat (hold) begin
      if (wiggle) begin a = W'($urandom); b = W'($urandom); sgn = 1'($urandom); end
      @(negedge clk);
    end
    if (hold > 0) begin
      chk({name, "_hold_z"}, 64'(z16), 64'(expz));
      chk({name, "_hold_zv"}, 64'(z_valid16), 64'd1);
      chk({name, "_hold_ready"}, 64'(ab_ready16), 64'd0);
    end
    z_ready = 1'b1;
    @(negedge clk);
    ab_valid = 1'b0;
    chk({name, "_taken_zv"}, 64'(z_valid16), 64'd0);
    chk({name, "_taken_ready"}, 64'(ab_ready16), 64'd1);
  endtask

  task automatic op8(input logic [W8-1:0] x, input logic [W8-1:0] y, input logic s,
                     input logic [ZW8-1:0] expz, input string name);
    int n;
    n = 0;
    while (!ab_ready8 && n < 50) begin @(negedge clk); n++; end
    a8 = x; b8 = y; sgn8 = s; ab_valid8 = 1'b1;
    @(negedge clk);
    ab_valid8 = 1'b0;
    n = 0;
    while (!z_valid8 && n < 40) begin @(negedge clk); n++; end
    chk({name, "_latency"}, 64'(n), 64'(W8));
    chk({name, "_z"}, 64'(z8), 64'(expz));
    @(negedge clk);
    chk({name, "_taken_zv"}, 64'(z_valid8), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; sgn = 1'b0; ab_valid = 1'b0; z_ready = 1'b1;
    a8 = '0; b8 = '0; sgn8 = 1'b0; ab_valid8 = 1'b0; z_ready8 = 1'b1;
    @(posedge clk);
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ab_ready16), 64'd0);
    chk("rst_zv",    64'(z_valid16),  64'd0);
    chk("rst_z",     64'(z16),        64'd0);
    chk("rst_busy",  64'(busy16),     64'd0);
    chk("rst_ready8", 64'(ab_ready8), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(ab_ready16), 64'd1);

    op16(16'hFFFF, 16'hFFFF, 1'b0, 33'h0_FFFE_0001, 0, 1'b0, "umax");
    op16(16'hFFFF, 16'h0003, 1'b1, 33'h1_FFFF_FFFD, 0, 1'b0, "smix");
    op16(16'h8000, 16'h8000, 1'b1, 33'h0_4000_0000, 0, 1'b0, "sminmin");
    op16(16'h8000, 16'h0001, 1'b1, 33'h1_FFFF_8000, 5, 1'b0, "backpress");
    op16(16'h1234, 16'h5678, 1'b0, 33'h0_0626_0060, 0, 1'b0, "b2b");
    op16(16'hFFF9, 16'h0009, 1'b1, 33'h1_FFFF_FFC1, 2, 1'b1, "wiggle");

    // Abort an operation with a one-edge reset five edges after accept.
    a = 16'h00FF; b = 16'h00FF; sgn = 1'b0; ab_valid = 1'b1;
    @(negedge clk);
    ab_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 64'(busy16), 64'd0);
    chk("abort_a_real", 64'(a_real16), 64'd0);
    repeat (25) begin
      @(negedge clk);
      chk("abort_zv", 64'(z_valid16), 64'd0);
    end
    op16(16'd7, 16'd6, 1'b0, 33'd42, 0, 1'b0, "after_abort");

    op8(8'd200, 8'd100, 1'b0, 17'h0_4E20, "w8_unsigned");
    op8(8'h80,  8'h7F,  1'b1, 17'h1_C080, "w8_signed");
    op8(8'h00,  8'h5A,  1'b0, 17'h0_0000, "w8_zero");

    for (int i = 0; i < 2500; i++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      ab_valid = ($urandom_range(0, 3) != 0);
      a        = pick();
      b        = pick();
      sgn      = 1'($urandom);
      z_ready  = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; ab_valid = 1'b0; z_ready = 1'b1;
    repeat (30) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
